n100_lm_icb_arb2: RTL
=====================

// Module: n100_lm_icb_arb2
// PURPOSE
//  2:1 ICB arbiter sharing one local-memory (ILM/DLM) ICB port between two requesters (m0 = IFU, m1 = LSU).
//  Sits in front of the lm_icb ctrl. Its stall_i input is the single stall point for the shared port.
//  Tracks outstanding commands in issue order and routes each in-order response back to its owner.
// PARAMETERS
//  AW          32  ICB address width
//  DW          32  ICB data width (wmask = DW/8)
//  OUTS_DEPTH  2   max outstanding cmds on slave port (>=1)
// PORTS
//  sys_clk             in   1         single clock
//  sys_rst             in   1         synchronous reset, active-high
//  stall_i             in   1         blocks cmd acceptance on slave side (TB force point)
//  mN_icb_cmd_valid    in   1         N=0,1: requester cmd valid
//  mN_icb_cmd_ready    out  1         requester cmd accepted
//  mN_icb_cmd_addr     in   AW        cmd address
//  mN_icb_cmd_read     in   1         1=read, 0=write
//  mN_icb_cmd_wdata    in   DW        write data
//  mN_icb_cmd_wmask    in   DW/8      byte mask
//  mN_icb_rsp_valid    out  1         response to requester
//  mN_icb_rsp_ready    in   1         requester takes response
//  mN_icb_rsp_rdata    out  DW        read data
//  mN_icb_rsp_err      out  1         response error
//  s_icb_cmd_*         out/in         slave cmd channel, same fields, directions mirrored
//  s_icb_rsp_*         in/out         slave rsp channel, same fields, directions mirrored
//  outs_cnt            out  $clog2(OUTS_DEPTH+1)  current outstanding count
//  arb_err             out  1         sticky: slave rsp_valid seen with no outstanding cmd
// BEHAVIOUR
//  - Reset (sync, sys_rst=1): outs FIFO empty, outs_cnt=0, lock=0, rr_last=M1 (m0 wins first tie),
//    arb_err=0; all mN_rsp_valid=0, s_cmd_valid=0, all cmd_ready=0 during reset cycle.
//  - Grant (combinational, 0-cycle cmd latency): if lock, gnt=lock_id; else only one valid -> it;
//    both valid -> requester != rr_last. No valid -> s_cmd_valid=0.
//  - s_cmd_valid = gnt_valid & ~stall_i & ~fifo_full. Fields muxed from gnt.
//    mN_cmd_ready = (gnt==N) & s_cmd_ready & ~stall_i & ~fifo_full.
//  - Lock: gnt_valid & ~cmd handshake -> lock=1, lock_id=gnt next cycle; cleared on handshake.
//    Grant never switches while granted cmd pending (ICB valid stability).
//  - On s cmd handshake: push gnt id into outs FIFO; rr_last<=gnt.
//  - Response: head id routes s_rsp_* to m<head>; s_rsp_ready = ~empty & m<head>_rsp_ready.
//    Other requester rsp_valid=0. Pop on s rsp handshake. Rsp latency added: 0 cycles.
//  - Full: push blocked when full even if same-cycle pop (no bypass). Empty: s_rsp_ready=0.
//    s_rsp_valid while empty -> arb_err<=1 (held until reset).
//  - Simultaneous push+pop when not full/empty: outs_cnt unchanged, order preserved.
//  - Pointer wrap: modulo OUTS_DEPTH; non-power-of-2 depths supported.
//  - Reset mid-operation: outstanding IDs discarded; slave must be reset in the same cycle.
//  - stall_i asserted mid-lock: lock held, cmd waits; no cmd dropped or duplicated.
// STRUCTURE
//  - Package n100_lm_icb_pkg: ICB width localparams, typedef enum {M0,M1} lm_req_id_t.
//  - Sub-module n100_lm_arb_id_fifo: sync FIFO of lm_req_id_t, depth OUTS_DEPTH, exposes full/empty/cnt.
//  - Top: grant/lock/rr logic, cmd mux, rsp demux, arb_err flop.
// TESTING
//  1 m0 read 0x8000_0000 only, s_cmd_ready=1 -> s_cmd_valid same cycle, outs_cnt=1; rsp routed to m0 only.
//  2 m0,m1 valid every cycle for 8 cmds -> grants alternate m0,m1,m0...; rsp order matches grants.
//  3 s_cmd_ready=0 for 3 cycles while m0 granted, m1 raises valid -> gnt stays m0 until handshake.
//  4 OUTS_DEPTH=2, rsp withheld -> 3rd cmd blocked (s_cmd_valid=0); one rsp pops -> 3rd issues next cycle.
//  5 stall_i=1 for 10 cycles, both valid -> no handshake, outs_cnt constant; release -> normal rr resumes.
//  6 s_rsp_valid=1 with outs_cnt=0 -> arb_err=1 next cycle, stays 1; sys_rst=1 -> arb_err=0, outs_cnt=0.

Source files
------------

// File: rtl/n100_lm_icb_pkg.sv
// Shared ICB widths and requester identifiers for the local-memory port arbiter.
package n100_lm_icb_pkg;

  localparam int unsigned LM_ICB_AW     = 32;
  localparam int unsigned LM_ICB_DW     = 32;
  localparam int unsigned LM_OUTS_DEPTH = 2;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } lm_req_id_t;

  function automatic lm_req_id_t lm_other(input lm_req_id_t id);
    return (id == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/n100_lm_arb_id_fifo.sv
// In-order record of which requester owns each outstanding slave command.
module n100_lm_arb_id_fifo
  import n100_lm_icb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  lm_req_id_t                 i_push_id,
  input  logic                       i_pop,
  output lm_req_id_t                 o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  lm_req_id_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Explicit wrap so depths that are not a power of two work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full    = (r_cnt == CNT_W'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_cnt     = r_cnt;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_id;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/n100_lm_icb_arb2.sv
// 2:1 round-robin ICB arbiter in front of the local-memory controller; responses
// return in order and are steered to the requester recorded at issue time.
module n100_lm_icb_arb2
  import n100_lm_icb_pkg::*;
#(
  parameter int AW         = LM_ICB_AW,
  parameter int DW         = LM_ICB_DW,
  parameter int OUTS_DEPTH = LM_OUTS_DEPTH
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst,
  input  logic                            stall_i,

  input  logic                            m0_icb_cmd_valid,
  output logic                            m0_icb_cmd_ready,
  input  logic [AW-1:0]                   m0_icb_cmd_addr,
  input  logic                            m0_icb_cmd_read,
  input  logic [DW-1:0]                   m0_icb_cmd_wdata,
  input  logic [DW/8-1:0]                 m0_icb_cmd_wmask,
  output logic                            m0_icb_rsp_valid,
  input  logic                            m0_icb_rsp_ready,
  output logic [DW-1:0]                   m0_icb_rsp_rdata,
  output logic                            m0_icb_rsp_err,

  input  logic                            m1_icb_cmd_valid,
  output logic                            m1_icb_cmd_ready,
  input  logic [AW-1:0]                   m1_icb_cmd_addr,
  input  logic                            m1_icb_cmd_read,
  input  logic [DW-1:0]                   m1_icb_cmd_wdata,
  input  logic [DW/8-1:0]                 m1_icb_cmd_wmask,
  output logic                            m1_icb_rsp_valid,
  input  logic                            m1_icb_rsp_ready,
  output logic [DW-1:0]                   m1_icb_rsp_rdata,
  output logic                            m1_icb_rsp_err,

  output logic                            s_icb_cmd_valid,
  input  logic                            s_icb_cmd_ready,
  output logic [AW-1:0]                   s_icb_cmd_addr,
  output logic                            s_icb_cmd_read,
  output logic [DW-1:0]                   s_icb_cmd_wdata,
  output logic [DW/8-1:0]                 s_icb_cmd_wmask,
  input  logic                            s_icb_rsp_valid,
  output logic                            s_icb_rsp_ready,
  input  logic [DW-1:0]                   s_icb_rsp_rdata,
  input  logic                            s_icb_rsp_err,

  output logic [$clog2(OUTS_DEPTH+1)-1:0] outs_cnt,
  output logic                            arb_err
);

  lm_req_id_t r_rr_last;
  lm_req_id_t r_lock_id;
  logic       r_lock;
  logic       r_arb_err;

  lm_req_id_t w_gnt;
  lm_req_id_t w_head;
  logic       w_gnt_valid;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       w_cmd_go;
  logic       w_cmd_hs;
  logic       w_rsp_route;
  logic       w_rsp_hs;

  // A granted-but-unaccepted requester keeps the grant so its command stays stable.
  always_comb begin
    w_gnt       = M0;
    w_gnt_valid = 1'b0;
    if (r_lock) begin
      w_gnt       = r_lock_id;
      w_gnt_valid = (r_lock_id == M1) ? m1_icb_cmd_valid : m0_icb_cmd_valid;
    end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
      w_gnt       = lm_other(r_rr_last);
      w_gnt_valid = 1'b1;
    end else if (m0_icb_cmd_valid) begin
      w_gnt       = M0;
      w_gnt_valid = 1'b1;
    end else if (m1_icb_cmd_valid) begin
      w_gnt       = M1;
      w_gnt_valid = 1'b1;
    end
  end

  assign w_cmd_go         = w_gnt_valid & ~stall_i & ~w_fifo_full & ~sys_rst;
  assign w_cmd_hs         = w_cmd_go & s_icb_cmd_ready;
  assign s_icb_cmd_valid  = w_cmd_go;
  assign m0_icb_cmd_ready = w_cmd_hs & (w_gnt == M0);
  assign m1_icb_cmd_ready = w_cmd_hs & (w_gnt == M1);

  assign s_icb_cmd_addr   = (w_gnt == M1) ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign s_icb_cmd_read   = (w_gnt == M1) ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign s_icb_cmd_wdata  = (w_gnt == M1) ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign s_icb_cmd_wmask  = (w_gnt == M1) ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

  // Response payload is broadcast; only the owner of the FIFO head sees valid.
  assign w_rsp_route      = ~w_fifo_empty & ~sys_rst;
  assign m0_icb_rsp_valid = w_rsp_route & (w_head == M0) & s_icb_rsp_valid;
  assign m1_icb_rsp_valid = w_rsp_route & (w_head == M1) & s_icb_rsp_valid;
  assign s_icb_rsp_ready  = w_rsp_route &
                            ((w_head == M1) ? m1_icb_rsp_ready : m0_icb_rsp_ready);
  assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
  assign m0_icb_rsp_err   = s_icb_rsp_err;
  assign m1_icb_rsp_err   = s_icb_rsp_err;
  assign w_rsp_hs         = s_icb_rsp_valid & s_icb_rsp_ready;

  assign arb_err          = r_arb_err;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_lock    <= 1'b0;
      r_lock_id <= M0;
      r_rr_last <= M1;
      r_arb_err <= 1'b0;
    end else begin
      r_lock <= w_gnt_valid & ~w_cmd_hs;
      if (w_gnt_valid && !w_cmd_hs) begin
        r_lock_id <= w_gnt;
      end
      if (w_cmd_hs) begin
        r_rr_last <= w_gnt;
      end
      // A response with nothing outstanding means the slave and arbiter disagree.
      if (s_icb_rsp_valid && w_fifo_empty) begin
        r_arb_err <= 1'b1;
      end
    end
  end

  n100_lm_arb_id_fifo #(
    .DEPTH (OUTS_DEPTH)
  ) u_id_fifo (
    .i_clk     (sys_clk),
    .i_rst     (sys_rst),
    .i_push    (w_cmd_hs),
    .i_push_id (w_gnt),
    .i_pop     (w_rsp_hs),
    .o_head    (w_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_cnt     (outs_cnt)
  );

endmodule
